// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: function codes, FSM states, default width.
package alu_pkg;

    localparam int ALU_WIDTH = 6;

    typedef enum logic [1:0] {
        FUNC_ADD = 2'b00,
        FUNC_SUB = 2'b01,
        FUNC_MUL = 2'b10,
        FUNC_DIV = 2'b11
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// One iteration of shift-add multiply or restoring divide on the {acc, q} pair.
// A single (width+1)-bit adder serves both: mul adds b (or 0) to acc,
// div subtracts b from {acc, q msb} via two's complement.
module alu_iter_unit #(
    parameter int width = 6
) (
    input  logic             is_div,
    input  logic [width-1:0] acc,
    input  logic [width-1:0] q,
    input  logic [width-1:0] b,
    output logic [width-1:0] acc_nxt,
    output logic [width-1:0] q_nxt
);

    logic [width:0]   lhs;
    logic [width:0]   rhs;
    logic [width+1:0] sum;

    // Shared adder plus per-operation result steering
    always_comb begin
        lhs = is_div ? {acc, q[width-1]} : {1'b0, acc};
        if (is_div) begin
            rhs = ~{1'b0, b};
        end else begin
            rhs = q[0] ? {1'b0, b} : '0;
        end
        sum = {1'b0, lhs} + {1'b0, rhs} + {{(width+1){1'b0}}, is_div};

        if (is_div) begin
            // Carry out of the subtract means the trial remainder is non-negative
            if (sum[width+1]) begin
                acc_nxt = sum[width-1:0];
                q_nxt   = {q[width-2:0], 1'b1};
            end else begin
                acc_nxt = lhs[width-1:0];
                q_nxt   = {q[width-2:0], 1'b0};
            end
        end else begin
            // Product shifts right one bit; the low sum bit enters the q register
            acc_nxt = sum[width:1];
            q_nxt   = {sum[0], q[width-1:1]};
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller: single-cycle add/sub, iterative mul/div (one bit per cycle),
// registered result with a one-cycle done pulse.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int width = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [width-1:0]   a,
    input  logic [width-1:0]   b,
    input  logic [1:0]         func,
    output logic               busy,
    output logic               done,
    output logic [2*width-1:0] out,
    output logic               ovf
);

    localparam int CW = (width > 1) ? $clog2(width) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(width - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [width-1:0]   acc_q, acc_d;
    logic [width-1:0]   q_q, q_d;
    logic [width-1:0]   b_q, b_d;
    logic               div_q, div_d;
    logic [2*width-1:0] out_q, out_d;
    logic               ovf_q, ovf_d;

    logic [width-1:0]   acc_nxt, q_nxt;
    logic [width:0]     add_res, sub_res;

    alu_iter_unit #(.width(width)) u_iter (
        .is_div  (div_q),
        .acc     (acc_q),
        .q       (q_q),
        .b       (b_q),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt)
    );

    // Next-state, datapath capture and result write
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        q_d     = q_q;
        b_d     = b_q;
        div_d   = div_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        add_res = {1'b0, a} + {1'b0, b};
        sub_res = {1'b0, a} - {1'b0, b};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (func_e'(func))
                        FUNC_ADD: begin
                            out_d   = {{width{1'b0}}, add_res[width-1:0]};
                            ovf_d   = add_res[width];
                            state_d = ST_DONE;
                        end
                        FUNC_SUB: begin
                            // Bit width of the extended difference is the borrow
                            out_d   = {{width{1'b0}}, sub_res[width-1:0]};
                            ovf_d   = sub_res[width];
                            state_d = ST_DONE;
                        end
                        default: begin
                            if (func_e'(func) == FUNC_DIV && b == '0) begin
                                out_d   = '1;
                                ovf_d   = 1'b1;
                                state_d = ST_DONE;
                            end else begin
                                acc_d   = '0;
                                q_d     = a;
                                b_d     = b;
                                div_d   = (func_e'(func) == FUNC_DIV);
                                count_d = CNT_INIT;
                                state_d = ST_CALC;
                            end
                        end
                    endcase
                end
            end
            ST_CALC: begin
                acc_d = acc_nxt;
                q_d   = q_nxt;
                if (count_q == '0) begin
                    out_d   = {acc_nxt, q_nxt};
                    ovf_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            b_q     <= b_d;
            div_q   <= div_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign out  = out_q;
    assign ovf  = ovf_q;

endmodule
